vx_mem_perf_monitor: RTL and testbench
======================================

VX_MEM_PERF_MONITOR -- requirements
Module: VX_mem_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 1, giving the number of monitored memory ports (1..8).
REQ-002 SHALL have parameter CTR_WIDTH, default 44, giving the width of the read, write and latency accumulators.
REQ-003 SHALL have parameter PEND_WIDTH, default 16, giving the width of the pending-read and peak counters.
REQ-004 SHALL have port clk, input, 1 bit: clock. Reset is reset, synchronous, active-high; clock is clk.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req_fire, input, NUM_PORTS bits: a memory request handshake completed on port i.
REQ-007 SHALL have port req_rw, input, NUM_PORTS bits: 1 = write and 0 = read, qualified by req_fire.
REQ-008 SHALL have port rsp_fire, input, NUM_PORTS bits: a read response handshake completed on port i.
REQ-009 SHALL have port enable, input, 1 bit: accumulate reads, writes and latency.
REQ-010 SHALL have port clear, input, 1 bit: zero the accumulators.
REQ-011 SHALL have port query_valid, input, 1 bit: counter read request.
REQ-012 SHALL have port query_ready, output, 1 bit: the monitor accepts a query.
REQ-013 SHALL have port query_port, input, 3 bits: port index.
REQ-014 SHALL have port query_sel, input, 3 bits: counter select.
REQ-015 SHALL have port rsp_valid, output, 1 bit: query result valid.
REQ-016 SHALL have port rsp_data, output, CTR_WIDTH bits: query result.
REQ-017 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-018 Per-port pending SHALL be computed as pending + (req_fire&~req_rw) - rsp_fire; a simultaneous read request and response SHALL leave it unchanged; it SHALL update regardless of enable.
REQ-019 A response with pending==0 SHALL hold pending at 0 and set the sticky err bit of that port.
REQ-020 A read request with pending at all-ones SHALL hold pending at all-ones and set err.
REQ-021 When enable=1, the per-port reads counter SHALL add 1 on a read request and the writes counter SHALL add 1 on a write request.
REQ-022 When enable=1, the per-port latency counter SHALL add the registered (pre-update) pending value each cycle.
REQ-023 The reads, writes and latency counters SHALL saturate at all-ones and SHALL never wrap.
REQ-024 peak SHALL be set to the max of peak and the new pending value every cycle, independent of enable.
REQ-025 clear SHALL zero reads, writes, latency, peak and err on the next edge, and SHALL take priority over same-cycle increments; pending SHALL keep updating normally.
REQ-026 query_sel encoding: 0=reads, 1=writes, 2=latency, 3=pending, 4=peak, 5=err (bit0), 6/7=0. Narrower values SHALL be zero-extended.
REQ-027 A query_port >= NUM_PORTS SHALL return 0.
REQ-028 query_ready SHALL be ~rsp_valid | rsp_ready.
REQ-029 A query accepted in cycle N SHALL assert rsp_valid in cycle N+1, with rsp_data equal to the counter value registered at the end of cycle N.
REQ-030 rsp_valid and rsp_data SHALL hold stable until rsp_ready=1.
REQ-031 A back-to-back query on the consumption cycle SHALL be accepted, giving 1 result per cycle throughput.

Reset
REQ-032 Reset SHALL zero all counters, err, rsp_valid and rsp_data; query_ready SHALL read 1 after reset.
REQ-033 Reset mid-query SHALL drop the pending response, and no rsp_valid SHALL appear afterward for that query.
REQ-034 Reset SHALL take priority over clear and over all events.

Structure
REQ-035 The query_sel encoding (mem_perf_sel_t) and its localparams SHALL live in VX_gpu_pkg.
REQ-036 A sub-module VX_mem_perf_port SHALL hold one port's counters, instantiated NUM_PORTS times via generate.
REQ-037 The top level SHALL contain only the query mux and the response register.
REQ-038 No combinational path SHALL exist from req_fire or rsp_fire to rsp_data.

Verification
REQ-039 Basic counting: NUM_PORTS=2, enable=1, port0 issues 3 reads in cycles 1-3 and 3 responses in cycles 6-8 -> pending=0, reads=3, peak=3, latency=1+2+3+3+3+2+1=15.
REQ-040 Enable gating: enable=0, 4 writes on port1 -> writes=0; then enable=1, 2 writes -> writes=2; pending stays 0.
REQ-041 Saturation and underflow: CTR_WIDTH=4, 20 reads with 20 responses -> reads=15 (saturated); an extra response with pending=0 -> pending=0 and err=1; clear -> err=0.
REQ-042 Clear priority: clear plus a simultaneous read request -> reads=0 and pending=1 on the next cycle.
REQ-043 Query handshake: 3 back-to-back queries with rsp_ready low for 2 cycles -> query_ready=0, data held stable, all 3 results delivered in order; query_port=5 with NUM_PORTS=2 -> 0.
REQ-044 Reset mid-query: assert reset in the cycle after a query is accepted -> rsp_valid=0 and all counters read 0.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Purpose: shared GPU definitions used by the memory performance monitor.
//   MEM_PERF_SEL_W    - width of the counter select field
//   MEM_PERF_PORT_W   - width of the port index field
//   MEM_PERF_MAX_PORTS- largest number of monitored ports (one per port index)
//   mem_perf_sel_t    - counter select encoding for monitor queries
package vx_gpu_pkg;

  localparam int unsigned MEM_PERF_SEL_W     = 3;
  localparam int unsigned MEM_PERF_PORT_W    = 3;
  localparam int unsigned MEM_PERF_MAX_PORTS = 8;

  typedef enum logic [MEM_PERF_SEL_W-1:0] {
    MEM_PERF_SEL_READS   = 3'd0,
    MEM_PERF_SEL_WRITES  = 3'd1,
    MEM_PERF_SEL_LATENCY = 3'd2,
    MEM_PERF_SEL_PENDING = 3'd3,
    MEM_PERF_SEL_PEAK    = 3'd4,
    MEM_PERF_SEL_ERR     = 3'd5,
    MEM_PERF_SEL_RSVD6   = 3'd6,
    MEM_PERF_SEL_RSVD7   = 3'd7
  } mem_perf_sel_t;

endpackage

// File: rtl/vx_mem_perf_port.sv
// Purpose: counters for a single monitored memory port.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   i_req_fire    - request handshake this cycle; i_req_rw 1=write 0=read
//   i_rsp_fire    - read response handshake this cycle
//   i_enable      - gate reads/writes/latency accumulation
//   i_clear       - zero reads/writes/latency/peak/err (pending unaffected)
//   o_reads, o_writes, o_latency - saturating accumulators
//   o_pending, o_peak            - outstanding reads and their high-water mark
//   o_err                        - sticky pending underflow/overflow flag
module vx_mem_perf_port #(
  parameter int unsigned CTR_WIDTH  = 44,
  parameter int unsigned PEND_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_fire,
  input  logic                  i_req_rw,
  input  logic                  i_rsp_fire,
  input  logic                  i_enable,
  input  logic                  i_clear,
  output logic [CTR_WIDTH-1:0]  o_reads,
  output logic [CTR_WIDTH-1:0]  o_writes,
  output logic [CTR_WIDTH-1:0]  o_latency,
  output logic [PEND_WIDTH-1:0] o_pending,
  output logic [PEND_WIDTH-1:0] o_peak,
  output logic                  o_err
);

  // One extra bit over the wider operand so the latency carry is never lost.
  localparam int unsigned SUM_W = ((CTR_WIDTH > PEND_WIDTH) ? CTR_WIDTH : PEND_WIDTH) + 1;

  logic [CTR_WIDTH-1:0]  r_reads;
  logic [CTR_WIDTH-1:0]  r_writes;
  logic [CTR_WIDTH-1:0]  r_latency;
  logic [PEND_WIDTH-1:0] r_pending;
  logic [PEND_WIDTH-1:0] r_peak;
  logic                  r_err;

  logic                  w_rd_req;
  logic                  w_wr_req;
  logic [PEND_WIDTH-1:0] w_pending_nxt;
  logic                  w_pend_err;
  logic [SUM_W-1:0]      w_lat_sum;
  logic [CTR_WIDTH-1:0]  w_lat_nxt;
  logic [PEND_WIDTH-1:0] w_peak_nxt;

  assign w_rd_req = i_req_fire & ~i_req_rw;
  assign w_wr_req = i_req_fire & i_req_rw;

  // Pending tracker: a read request and a response in the same cycle cancel out.
  always_comb begin
    w_pending_nxt = r_pending;
    w_pend_err    = 1'b0;
    case ({w_rd_req, i_rsp_fire})
      2'b10: begin
        if (&r_pending) w_pend_err = 1'b1;
        else            w_pending_nxt = r_pending + PEND_WIDTH'(1);
      end
      2'b01: begin
        if (r_pending == '0) w_pend_err = 1'b1;
        else                 w_pending_nxt = r_pending - PEND_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Latency integrates the pre-update pending count, clamped at all-ones.
  assign w_lat_sum  = SUM_W'(r_latency) + SUM_W'(r_pending);
  assign w_lat_nxt  = (|(w_lat_sum >> CTR_WIDTH)) ? '1 : w_lat_sum[CTR_WIDTH-1:0];
  assign w_peak_nxt = (w_pending_nxt > r_peak) ? w_pending_nxt : r_peak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reads   <= '0;
      r_writes  <= '0;
      r_latency <= '0;
      r_pending <= '0;
      r_peak    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (i_clear) begin
        r_reads   <= '0;
        r_writes  <= '0;
        r_latency <= '0;
        r_peak    <= '0;
        r_err     <= 1'b0;
      end else begin
        if (i_enable) begin
          if (w_rd_req && !(&r_reads))  r_reads  <= r_reads + CTR_WIDTH'(1);
          if (w_wr_req && !(&r_writes)) r_writes <= r_writes + CTR_WIDTH'(1);
          r_latency <= w_lat_nxt;
        end
        r_peak <= w_peak_nxt;
        r_err  <= r_err | w_pend_err;
      end
    end
  end

  assign o_reads   = r_reads;
  assign o_writes  = r_writes;
  assign o_latency = r_latency;
  assign o_pending = r_pending;
  assign o_peak    = r_peak;
  assign o_err     = r_err;

endmodule

// File: rtl/vx_mem_perf_monitor.sv
// Purpose: per-port memory performance counters with a valid/ready query port.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   req_fire/req_rw/rsp_fire- per-port request (1=write) and read-response events
//   enable, clear           - accumulation gate, accumulator clear
//   query_valid/query_ready - query handshake; query_port, query_sel pick the counter
//   rsp_valid/rsp_ready     - result handshake; rsp_data holds the selected counter
module vx_mem_perf_monitor
  import vx_gpu_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 1,
  parameter int unsigned CTR_WIDTH  = 44,
  parameter int unsigned PEND_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_fire,
  input  logic [NUM_PORTS-1:0]       req_rw,
  input  logic [NUM_PORTS-1:0]       rsp_fire,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       query_valid,
  output logic                       query_ready,
  input  logic [MEM_PERF_PORT_W-1:0] query_port,
  input  logic [MEM_PERF_SEL_W-1:0]  query_sel,
  output logic                       rsp_valid,
  output logic [CTR_WIDTH-1:0]       rsp_data,
  input  logic                       rsp_ready
);

  // Arrays span every encodable port index; absent ports read as zero.
  logic [CTR_WIDTH-1:0]          w_reads   [MEM_PERF_MAX_PORTS];
  logic [CTR_WIDTH-1:0]          w_writes  [MEM_PERF_MAX_PORTS];
  logic [CTR_WIDTH-1:0]          w_latency [MEM_PERF_MAX_PORTS];
  logic [PEND_WIDTH-1:0]         w_pending [MEM_PERF_MAX_PORTS];
  logic [PEND_WIDTH-1:0]         w_peak    [MEM_PERF_MAX_PORTS];
  logic [MEM_PERF_MAX_PORTS-1:0] w_err;

  logic                 r_rsp_valid;
  logic [CTR_WIDTH-1:0] r_rsp_data;
  logic [CTR_WIDTH-1:0] w_qdata;
  logic                 w_accept;
  mem_perf_sel_t        w_sel;

  for (genvar p = 0; p < MEM_PERF_MAX_PORTS; p++) begin : g_port
    if (p < NUM_PORTS) begin : g_on
      vx_mem_perf_port #(
        .CTR_WIDTH  (CTR_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
      ) u_port (
        .clk        (clk),
        .reset      (reset),
        .i_req_fire (req_fire[p]),
        .i_req_rw   (req_rw[p]),
        .i_rsp_fire (rsp_fire[p]),
        .i_enable   (enable),
        .i_clear    (clear),
        .o_reads    (w_reads[p]),
        .o_writes   (w_writes[p]),
        .o_latency  (w_latency[p]),
        .o_pending  (w_pending[p]),
        .o_peak     (w_peak[p]),
        .o_err      (w_err[p])
      );
    end else begin : g_off
      assign w_reads[p]   = '0;
      assign w_writes[p]  = '0;
      assign w_latency[p] = '0;
      assign w_pending[p] = '0;
      assign w_peak[p]    = '0;
      assign w_err[p]     = 1'b0;
    end
  end

  // Query mux reads only registered counters, so events never reach rsp_data combinationally.
  always_comb begin
    w_qdata = '0;
    w_sel   = mem_perf_sel_t'(query_sel);
    case (w_sel)
      MEM_PERF_SEL_READS:   w_qdata = w_reads[query_port];
      MEM_PERF_SEL_WRITES:  w_qdata = w_writes[query_port];
      MEM_PERF_SEL_LATENCY: w_qdata = w_latency[query_port];
      MEM_PERF_SEL_PENDING: w_qdata = CTR_WIDTH'(w_pending[query_port]);
      MEM_PERF_SEL_PEAK:    w_qdata = CTR_WIDTH'(w_peak[query_port]);
      MEM_PERF_SEL_ERR:     w_qdata = CTR_WIDTH'(w_err[query_port]);
      default:              w_qdata = '0;
    endcase
  end

  // Result slot may be refilled on the cycle it is consumed.
  assign query_ready = ~r_rsp_valid | rsp_ready;
  assign w_accept    = query_valid & query_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_qdata;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Directed bench: two monitors share stimulus; u_dut uses wide counters,
// u_sat uses CTR_WIDTH=4/PEND_WIDTH=2 to exercise saturation.
module tb_vx_mem_perf_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_fire, req_rw, rsp_fire;
  logic        enable, clear, query_valid, rsp_ready;
  logic [2:0]  query_port, query_sel;
  logic        qr_m, rv_m, qr_s, rv_s;
  logic [43:0] rd_m;
  logic [3:0]  rd_s;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] fire;
    logic [1:0] rw;
    logic [1:0] rsp;
    logic       en;
    logic       clr;
  } stim_t;

  typedef struct {
    string       name;
    logic [2:0]  port;
    logic [2:0]  sel;
    logic [63:0] exp_m;
    logic [63:0] exp_s;
  } qvec_t;

  qvec_t tbl[$];

  always #5 clk = ~clk;

  vx_mem_perf_monitor #(.NUM_PORTS(2), .CTR_WIDTH(44), .PEND_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_rw(req_rw), .rsp_fire(rsp_fire),
    .enable(enable), .clear(clear), .query_valid(query_valid), .query_ready(qr_m),
    .query_port(query_port), .query_sel(query_sel), .rsp_valid(rv_m), .rsp_data(rd_m),
    .rsp_ready(rsp_ready)
  );

  vx_mem_perf_monitor #(.NUM_PORTS(2), .CTR_WIDTH(4), .PEND_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_rw(req_rw), .rsp_fire(rsp_fire),
    .enable(enable), .clear(clear), .query_valid(query_valid), .query_ready(qr_s),
    .query_port(query_port), .query_sel(query_sel), .rsp_valid(rv_s), .rsp_data(rd_s),
    .rsp_ready(rsp_ready)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    req_fire = s.fire; req_rw = s.rw; rsp_fire = s.rsp; enable = s.en; clear = s.clr;
    cyc();
    req_fire = '0; req_rw = '0; rsp_fire = '0; clear = 1'b0;
  endtask

  task automatic add(input string name, input logic [2:0] port, input logic [2:0] sel,
                     input logic [63:0] em, input logic [63:0] es);
    qvec_t q;
    q.name = name; q.port = port; q.sel = sel; q.exp_m = em; q.exp_s = es;
    tbl.push_back(q);
  endtask

  // Single query with rsp_ready held high; returns both monitors' results.
  task automatic query(input string name, input logic [2:0] port, input logic [2:0] sel,
                       output logic [63:0] dm, output logic [63:0] ds);
    query_port = port; query_sel = sel; query_valid = 1'b1; rsp_ready = 1'b1;
    cyc();
    query_valid = 1'b0;
    #1;
    check({name, " valid"}, {62'b0, rv_s, rv_m}, 64'h3);
    dm = 64'(rd_m);
    ds = 64'(rd_s);
    cyc();
  endtask

  task automatic run_tbl();
    logic [63:0] dm, ds;
    foreach (tbl[i]) begin
      query(tbl[i].name, tbl[i].port, tbl[i].sel, dm, ds);
      check({tbl[i].name, " main"}, dm, tbl[i].exp_m);
      check({tbl[i].name, " sat"}, ds, tbl[i].exp_s);
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t basic[8];
    reset = 1'b1; req_fire = '0; req_rw = '0; rsp_fire = '0; enable = 1'b0; clear = 1'b0;
    query_valid = 1'b0; rsp_ready = 1'b0; query_port = '0; query_sel = '0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check("reset qready", {62'b0, qr_s, qr_m}, 64'h3);
    check("reset rvalid", {62'b0, rv_s, rv_m}, 64'h0);
    check("reset rdata", 64'(rd_m), 64'h0);
    cyc();
    enable = 1'b1;

    // Basic counting: 3 reads on port0, responses 3 cycles later.
    basic[0] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    basic[1] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    basic[2] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    basic[3] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    basic[4] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    basic[5] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    basic[6] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    basic[7] = '{2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    foreach (basic[i]) apply(basic[i]);
    add("b p0 reads",   3'd0, 3'd0, 64'd3,  64'd3);
    add("b p0 writes",  3'd0, 3'd1, 64'd0,  64'd0);
    add("b p0 latency", 3'd0, 3'd2, 64'd15, 64'd15);
    add("b p0 pending", 3'd0, 3'd3, 64'd0,  64'd0);
    add("b p0 peak",    3'd0, 3'd4, 64'd3,  64'd3);
    add("b p0 err",     3'd0, 3'd5, 64'd0,  64'd0);
    add("b p1 reads",   3'd1, 3'd0, 64'd0,  64'd0);
    add("b port5",      3'd5, 3'd0, 64'd0,  64'd0);
    add("b sel6",       3'd0, 3'd6, 64'd0,  64'd0);
    run_tbl();

    // Back-to-back queries with a two-cycle consumer stall.
    query_port = 3'd0; query_sel = 3'd0; query_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    check("hs accept1 qready", {63'b0, qr_m}, 64'h1);
    cyc();
    query_sel = 3'd2;
    #1;
    check("hs stall1 valid", {63'b0, rv_m}, 64'h1);
    check("hs stall1 data", 64'(rd_m), 64'd3);
    check("hs stall1 qready", {62'b0, qr_s, qr_m}, 64'h0);
    cyc();
    #1;
    check("hs stall2 data", 64'(rd_m), 64'd3);
    check("hs stall2 qready", {63'b0, qr_m}, 64'h0);
    cyc();
    rsp_ready = 1'b1;
    #1;
    check("hs release qready", {63'b0, qr_m}, 64'h1);
    check("hs release data", 64'(rd_m), 64'd3);
    cyc();
    query_sel = 3'd4;
    #1;
    check("hs r2 valid", {63'b0, rv_m}, 64'h1);
    check("hs r2 data", 64'(rd_m), 64'd15);
    cyc();
    query_valid = 1'b0;
    #1;
    check("hs r3 valid", {63'b0, rv_m}, 64'h1);
    check("hs r3 data", {rd_s, rd_m}, {4'd3, 44'd3});
    cyc();
    #1;
    check("hs drained", {62'b0, rv_s, rv_m}, 64'h0);
    cyc();

    // Enable gating on port1 writes.
    repeat (4) apply('{2'b10, 2'b10, 2'b00, 1'b0, 1'b0});
    repeat (2) apply('{2'b10, 2'b10, 2'b00, 1'b1, 1'b0});
    add("g p1 writes",  3'd1, 3'd1, 64'd2, 64'd2);
    add("g p1 pending", 3'd1, 3'd3, 64'd0, 64'd0);
    add("g p1 reads",   3'd1, 3'd0, 64'd0, 64'd0);
    add("g p0 writes",  3'd0, 3'd1, 64'd0, 64'd0);
    run_tbl();

    // Saturation: 20 read/response pairs, then an underflowing response.
    for (int i = 0; i < 20; i++) begin
      apply('{2'b01, 2'b00, 2'b00, 1'b1, 1'b0});
      apply('{2'b00, 2'b00, 2'b01, 1'b1, 1'b0});
    end
    apply('{2'b00, 2'b00, 2'b01, 1'b1, 1'b0});
    add("s p0 reads",   3'd0, 3'd0, 64'd23, 64'd15);
    add("s p0 latency", 3'd0, 3'd2, 64'd35, 64'd15);
    add("s p0 pending", 3'd0, 3'd3, 64'd0,  64'd0);
    add("s p0 err",     3'd0, 3'd5, 64'd1,  64'd1);
    add("s p0 peak",    3'd0, 3'd4, 64'd3,  64'd3);
    run_tbl();
    apply('{2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
    add("c p0 err",     3'd0, 3'd5, 64'd0, 64'd0);
    add("c p0 reads",   3'd0, 3'd0, 64'd0, 64'd0);
    add("c p0 latency", 3'd0, 3'd2, 64'd0, 64'd0);
    add("c p0 peak",    3'd0, 3'd4, 64'd0, 64'd0);
    add("c p1 writes",  3'd1, 3'd1, 64'd0, 64'd0);
    run_tbl();

    // Clear wins over a same-cycle read; pending still advances.
    apply('{2'b01, 2'b00, 2'b00, 1'b1, 1'b1});
    add("cp p0 reads",   3'd0, 3'd0, 64'd0, 64'd0);
    add("cp p0 pending", 3'd0, 3'd3, 64'd1, 64'd1);
    run_tbl();

    // Pending overflow in the 2-bit instance.
    repeat (3) apply('{2'b01, 2'b00, 2'b00, 1'b1, 1'b0});
    add("o p0 pending", 3'd0, 3'd3, 64'd4, 64'd3);
    add("o p0 err",     3'd0, 3'd5, 64'd0, 64'd1);
    add("o p0 peak",    3'd0, 3'd4, 64'd4, 64'd3);
    add("o p0 reads",   3'd0, 3'd0, 64'd3, 64'd3);
    run_tbl();

    // Reset the cycle after a query is accepted.
    query_port = 3'd0; query_sel = 3'd3; query_valid = 1'b1; rsp_ready = 1'b0;
    cyc();
    query_valid = 1'b0; reset = 1'b1;
    #1;
    check("rq pre valid", {63'b0, rv_m}, 64'h1);
    cyc();
    reset = 1'b0;
    #1;
    check("rq dropped valid", {62'b0, rv_s, rv_m}, 64'h0);
    check("rq dropped data", {rd_s, rd_m}, 64'h0);
    repeat (3) cyc();
    #1;
    check("rq no late valid", {62'b0, rv_s, rv_m}, 64'h0);
    check("rq qready", {62'b0, qr_s, qr_m}, 64'h3);
    cyc();
    add("r p0 reads",   3'd0, 3'd0, 64'd0, 64'd0);
    add("r p0 latency", 3'd0, 3'd2, 64'd0, 64'd0);
    add("r p0 pending", 3'd0, 3'd3, 64'd0, 64'd0);
    add("r p0 peak",    3'd0, 3'd4, 64'd0, 64'd0);
    add("r p0 err",     3'd0, 3'd5, 64'd0, 64'd0);
    run_tbl();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
